// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave front end: FSM state encodings and default sizing.
package spi_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;

  localparam int unsigned DefaultWidth = 8;
  // clk must run at least this many times faster than sclk for edge detection to hold.
  localparam int unsigned MinSclkRatio = 4;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input, with level and edge-detect outputs.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to 0 so a chip enable held low through reset never looks like a fresh frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_frontend.sv
// Oversampled SPI mode-0 slave: deserialises MOSI into words, serialises a shadowed tx word on MISO.
// Optional build macro SPI_LOOPBACK_EN: an empty-shadow load resends the last received word.
module spi_slave_frontend
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             ce0_n,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic             tx_underrun
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic sclk_rise, sclk_fall;
  logic mosi_s;
  logic ce_rise, ce_fall;
  logic sclk_lvl, ce_lvl;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sclk),
    .level_o(sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (mosi),
    .level_o(mosi_s),
    .rise_o (),
    .fall_o ()
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ce (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (ce0_n),
    .level_o(ce_lvl),
    .rise_o (ce_rise),
    .fall_o (ce_fall)
  );

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             reload_q, reload_d;
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             underrun_q, underrun_d;

  logic             do_load;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] empty_word;

`ifdef SPI_LOOPBACK_EN
  assign empty_word = rx_data_q;
`else
  assign empty_word = '0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    reload_d      = reload_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    underrun_d    = 1'b0;
    do_load       = 1'b0;
    rx_next       = {rx_shift_q, mosi_s};
    load_word     = shadow_full_q ? shadow_q : empty_word;

    // Only an empty shadow accepts, so an offer never collides with a load consuming it.
    if (tx_valid && !shadow_full_q) begin
      shadow_d      = tx_data;
      shadow_full_d = 1'b1;
    end

    if (ce_rise) begin
      state_d    = StIdle;
      cnt_d      = '0;
      reload_d   = 1'b0;
      rx_shift_d = '0;
      tx_shift_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          tx_shift_d = '0;
          if (ce_fall) state_d = StLoad;
        end
        StLoad: begin
          do_load  = 1'b1;
          cnt_d    = '0;
          reload_d = 1'b0;
          state_d  = StShift;
        end
        StShift: begin
          if (sclk_rise) begin
            rx_shift_d = rx_next[WIDTH-2:0];
            if (cnt_q == CntW'(WIDTH - 1)) begin
              cnt_d      = '0;
              reload_d   = 1'b1;
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end else if (sclk_fall) begin
            if (reload_q) begin
              do_load  = 1'b1;
              reload_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (do_load) begin
      tx_shift_d = load_word;
      if (shadow_full_q) shadow_full_d = 1'b0;
      else underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      reload_q      <= 1'b0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reload_q      <= reload_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      underrun_q    <= underrun_d;
    end
  end

  // MISO is driven straight from the tx shift MSB; the register is cleared whenever idle.
  assign miso        = tx_shift_q[WIDTH-1];
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~shadow_full_q;
  assign busy        = (state_q != StIdle);
  assign tx_underrun = underrun_q;

  // Level outputs of the edge-detecting synchronisers are not needed beyond edges.
  logic unused_lvl;
  assign unused_lvl = sclk_lvl ^ ce_lvl;

endmodule

// File: doc/spi_slave_frontend.md
Name: spi_slave_frontend

Overview:
- Clock-domain SPI slave front end for the Raspberry Pi link. Upstream of the byte consumer.
- Oversamples the Pi's sclk, mosi and ce0_n in the clk domain, then deserialises MOSI into WIDTH-bit words with a valid pulse.
- Serialises queued transmit words onto miso. SPI mode 0, MSB first.
- Replaces the direct SCLK-clocked capture at top level; nothing runs on sclk as a clock.

Parameters:
- WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, flip-flops per input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock, 12 MHz on iCEstick.
- rst_n  in  1  reset, synchronous, active-low.
- sclk  in  1  SPI clock from master, asynchronous.
- mosi  in  1  SPI data from master, asynchronous.
- ce0_n  in  1  chip enable from master, active-low, asynchronous.
- miso  out  1  SPI data to master.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-clk pulse when rx_data updates.
- tx_data  in  WIDTH  next word to send.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  tx shadow register is empty.
- busy  out  1  frame in progress (ce0_n synced low).
- tx_underrun  out  1  one-clk pulse when a word is loaded with the shadow empty.

Behaviour:
- Reset (rst_n low at a clk edge): miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, tx_underrun=0. State=IDLE, bit counter=0, shift registers=0, shadow empty.
- Synchronisation:
  - sclk, mosi and ce0_n each pass through SYNC_STAGES flops.
  - Edge detect compares the last two synced sclk/ce0_n samples.
  - mosi is taken from the same pipeline depth as sclk, so the sampled bit is aligned with the detected edge.
  - Requirement: f_clk >= 4 x f_sclk (sclk <= 3 MHz at 12 MHz).
- FSM states:
  - IDLE: ce0_n synced high. busy=0, miso=0. sclk edges ignored. Synced ce0_n falling -> LOAD.
  - LOAD (one clk):
    - Tx shift register <= shadow if full (shadow becomes empty), else 0 with a tx_underrun pulse.
    - miso <= MSB.
    - Bit counter=0. busy=1. -> SHIFT.
  - SHIFT:
    - Synced sclk rising: rx shift <= {rx shift[WIDTH-2:0], mosi}; counter++.
    - On the WIDTH-th rise: rx_data <= completed word and rx_valid=1 in the next clk; counter wraps to 0 and a reload flag is set.
    - Synced sclk falling: if the reload flag is set, perform the LOAD action in place (flag clears, stay in SHIFT); else shift the tx register left and miso <= new MSB.
    - Synced ce0_n rising -> IDLE from any state.
- Multi-word frames: unlimited back-to-back words while ce0_n stays low. Each word gets its own rx_valid pulse and its own tx load.
- CE deassert mid-word:
  - Partial rx bits are discarded; no rx_valid.
  - Counter reset. miso=0 in the next clk.
  - The loaded tx word is consumed, not replayed.
- tx handshake:
  - Transfer when tx_valid && tx_ready at a clk edge. Shadow <= tx_data; tx_ready=0 from the next clk.
  - tx_ready returns to 1 the clk after the shadow is consumed.
  - No same-cycle bypass: if the shadow is consumed in the cycle tx_valid is presented, tx_ready is already 0, so the offer waits one clk.
- rx has no backpressure: the consumer must take rx_data on the rx_valid pulse. rx_data holds until the next word.
- Simultaneous synced ce0_n rising and sclk edge in one clk: ce0_n wins; the edge is ignored.

Optional Feature:
- Macro SPI_LOOPBACK_EN.
  - Defined: a load with the shadow empty sends the most recent rx_data instead of 0; tx_underrun still pulses.
  - Undefined: empty load sends 0.

Decomposition:
- Shared package spi_pkg: state enum (IDLE, LOAD, SHIFT), default WIDTH constant, minimum sclk-to-clk ratio constant.
- One sub-module spi_sync: SYNC_STAGES-deep synchroniser with rise/fall outputs. Instantiated for sclk, mosi and ce0_n; the mosi instance uses the level output only.

Test Plan:
- Reset, then idle: all outputs at reset values; sclk toggling with ce0_n high -> no rx_valid, miso=0.
- Single word: tx offered 0xA5, frame sends MOSI 0x3C at sclk = clk/4 -> MISO bits 1,0,1,0,0,1,0,1; exactly one rx_valid; rx_data=0x3C.
- Three-word frame: shadow refilled with 0x01, 0x02, 0x03 between words; MOSI 0x10, 0x20, 0x30 -> three rx_valid pulses in order; MISO carries 0x01, 0x02, 0x03.
- Underrun: frame started with shadow empty -> tx_underrun pulses once; MISO all 0. With SPI_LOOPBACK_EN and previous rx 0x5A -> MISO 0x5A.
- Abort: ce0_n raised after 5 bits of 0xFF -> no rx_valid; the next full frame with 0x81 -> rx_data=0x81.
- Sync reset mid-frame: rst_n low for one clk at bit 4 -> outputs at reset values next clk; the remainder of the frame produces no rx_valid until a fresh ce0_n fall.
